alu_sequencer: RTL and testbench

Multi-cycle controller that sits between the instruction-issue side and the combinational ALU and Shifter datapath. It accepts one operation at a time over a valid/ready handshake and latches the operands. It drives the opcode and operands onto the ALU or Shifter, runs MULTU as a 32-step shift-add sequence into internal HI/LO registers, and returns each result over a valid/ready response port.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/multu_step.sv | 20 ++
 rtl/alu_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared function codes, state encoding and width for the ALU sequencer
package alu_pkg;

   localparam int W = 32;

   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_NOP   = 6'b000000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MUL,
      S_RESP
   } state_t;

   function automatic logic is_alu_op(input logic [5:0] f);
      return (f == F_AND) || (f == F_OR) || (f == F_ADD) || (f == F_SUB) || (f == F_SLT);
   endfunction

endpackage

// File: rtl/multu_step.sv
// rtl/multu_step.sv - one shift-add step of the unsigned multiply into {hi,lo}
module multu_step
   import alu_pkg::*;
(
   input  logic [W-1:0] hi,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] mcand,
   output logic [W-1:0] hi_next,
   output logic [W-1:0] lo_next
);

   logic [W:0] sum;

   // The carry out of the add lands in hi_next[W-1] so no product bit is lost.
   always_comb begin
      sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(W+1){1'b0}});
      {hi_next, lo_next} = {sum, lo[W-1:1]};
   end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle controller between the issue handshake and the ALU/Shifter datapath
module alu_sequencer
   import alu_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [5:0]    req_funct,
   input  logic [W-1:0]  req_a,
   input  logic [W-1:0]  req_b,
   input  logic [4:0]    req_shamt,
   output logic [5:0]    alu_signal,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   input  logic [W-1:0]  alu_result,
   output logic [5:0]    shf_signal,
   output logic [W-1:0]  shf_data,
   output logic [W-1:0]  shf_shamt,
   input  logic [W-1:0]  shf_result,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [W-1:0]  rsp_result,
   output logic          rsp_err,
   output logic          busy
);

   state_t         state;
   state_t         state_next;
   logic [5:0]     funct_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [4:0]     shamt_q;
   logic [W-1:0]   hi;
   logic [W-1:0]   lo;
   logic [W-1:0]   hi_next;
   logic [W-1:0]   lo_next;
   logic [4:0]     cnt;
   logic [W-1:0]   result_q;
   logic           err_q;
   logic [W-1:0]   exec_result;
   logic           exec_err;

   multu_step u_multu_step (
      .hi      (hi),
      .lo      (lo),
      .mcand   (a_q),
      .hi_next (hi_next),
      .lo_next (lo_next)
   );

   assign req_ready  = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   assign rsp_valid  = (state == S_RESP);
   assign rsp_result = result_q;
   assign rsp_err    = err_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign shf_data   = b_q;
   assign shf_shamt  = {27'b0, shamt_q};

   // Opcodes are only asserted during EXEC; elsewhere the Shifter sits in pass-through.
   always_comb begin
      state_next  = state;
      alu_signal  = F_NOP;
      shf_signal  = F_NOP;
      exec_result = '0;
      exec_err    = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               state_next = (req_funct == F_MULTU) ? S_MUL : S_EXEC;
            end
         end
         S_EXEC: begin
            state_next = S_RESP;
            if (is_alu_op(funct_q)) begin
               alu_signal  = funct_q;
               exec_result = alu_result;
            end else if (funct_q == F_SRL) begin
               shf_signal  = F_SRL;
               exec_result = shf_result;
            end else if (funct_q == F_MFHI) begin
               exec_result = hi;
            end else if (funct_q == F_MFLO) begin
               exec_result = lo;
            end else begin
               exec_err = 1'b1;
            end
         end
         S_MUL: begin
            if (cnt == 5'd31) begin
               state_next = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         funct_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         shamt_q  <= '0;
         hi       <= '0;
         lo       <= '0;
         cnt      <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  funct_q <= req_funct;
                  a_q     <= req_a;
                  b_q     <= req_b;
                  shamt_q <= req_shamt;
                  if (req_funct == F_MULTU) begin
                     hi  <= '0;
                     lo  <= req_b;
                     cnt <= '0;
                  end
               end
            end
            S_EXEC: begin
               result_q <= exec_result;
               err_q    <= exec_err;
            end
            S_MUL: begin
               hi  <= hi_next;
               lo  <= lo_next;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  result_q <= lo_next;
                  err_q    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with behavioural ALU/Shifter
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_funct;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_shamt;
   logic [5:0]  alu_signal;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic [5:0]  shf_signal;
   logic [31:0] shf_data;
   logic [31:0] shf_shamt;
   logic [31:0] shf_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_err;
   logic        busy;

   int errors = 0;
   int checks = 0;

   alu_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_funct  (req_funct),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_shamt  (req_shamt),
      .alu_signal (alu_signal),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .shf_signal (shf_signal),
      .shf_data   (shf_data),
      .shf_shamt  (shf_shamt),
      .shf_result (shf_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Behavioural ALU and Shifter; unknown opcodes give a poison value.
   always_comb begin
      case (alu_signal)
         6'b100100: alu_result = alu_a & alu_b;
         6'b100101: alu_result = alu_a | alu_b;
         6'b100000: alu_result = alu_a + alu_b;
         6'b100010: alu_result = alu_a - alu_b;
         6'b101010: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default:   alu_result = 32'hDEADBEEF;
      endcase
      shf_result = (shf_signal == 6'b000010) ? (shf_data >> shf_shamt[4:0]) : shf_data;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
      req_funct = f;
      req_a     = a;
      req_b     = b;
      req_shamt = sh;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int cycles);
      cycles = 0;
      while (!rsp_valid && cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic take_rsp(input string tag);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check_eq({tag, "_ready_after"}, {31'b0, req_ready}, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] exp_res, input logic exp_err, input int exp_lat);
      int lat;
      send(f, a, b, sh);
      wait_rsp(lat);
      check_eq({tag, "_latency"}, lat, exp_lat);
      check_eq({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
      check_eq({tag, "_result"}, rsp_result, exp_res);
      check_eq({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
      take_rsp(tag);
   endtask

   initial begin
      int lat;
      int busy_cycles;
      logic [31:0] held;

      reset     = 1'b1;
      req_valid = 1'b0;
      req_funct = '0;
      req_a     = '0;
      req_b     = '0;
      req_shamt = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_rsp_result", rsp_result, 32'd0);
      check_eq("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      check_eq("rst_alu_signal", {26'b0, alu_signal}, 32'd0);
      check_eq("rst_shf_signal", {26'b0, shf_signal}, 32'd0);
      check_eq("rst_alu_a", alu_a, 32'd0);

      // ADD with EXEC-cycle drive checks
      send(6'b100000, 32'd5, 32'd7, 5'd0);
      check_eq("add_alu_signal", {26'b0, alu_signal}, 32'h20);
      check_eq("add_alu_a", alu_a, 32'd5);
      check_eq("add_alu_b", alu_b, 32'd7);
      check_eq("add_busy", {31'b0, busy}, 32'd1);
      check_eq("add_req_ready", {31'b0, req_ready}, 32'd0);
      check_eq("add_rsp_valid_exec", {31'b0, rsp_valid}, 32'd0);
      wait_rsp(lat);
      check_eq("add_latency", lat, 32'd1);
      check_eq("add_result", rsp_result, 32'd12);
      check_eq("add_err", {31'b0, rsp_err}, 32'd0);
      check_eq("add_alu_signal_resp", {26'b0, alu_signal}, 32'd0);
      take_rsp("add");

      run_op("sub", 6'b100010, 32'd3, 32'd5, 5'd0, 32'hFFFFFFFE, 1'b0, 1);
      run_op("slt", 6'b101010, 32'd3, 32'd5, 5'd0, 32'd1, 1'b0, 1);
      run_op("slt_neg", 6'b101010, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1);
      run_op("and", 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 1'b0, 1);

      // SRL at maximum shift
      send(6'b000010, 32'd0, 32'h80000000, 5'd31);
      check_eq("srl_shf_signal", {26'b0, shf_signal}, 32'h02);
      check_eq("srl_shf_shamt", shf_shamt, 32'd31);
      check_eq("srl_shf_data", shf_data, 32'h80000000);
      check_eq("srl_alu_signal", {26'b0, alu_signal}, 32'd0);
      wait_rsp(lat);
      check_eq("srl_result", rsp_result, 32'h00000001);
      check_eq("srl_shf_signal_after", {26'b0, shf_signal}, 32'd0);
      take_rsp("srl");

      // MULTU of max operands: every busy cycle up to the response is counted
      send(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
      busy_cycles = 1;
      lat = 0;
      while (!rsp_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) busy_cycles++;
      end
      check_eq("multu_latency", lat, 32'd32);
      check_eq("multu_busy_cycles", busy_cycles, 32'd33);
      check_eq("multu_result", rsp_result, 32'h00000001);
      check_eq("multu_err", {31'b0, rsp_err}, 32'd0);
      take_rsp("multu");
      run_op("mfhi", 6'b010000, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFE, 1'b0, 1);
      run_op("mflo", 6'b010010, 32'd0, 32'd0, 5'd0, 32'h00000001, 1'b0, 1);

      run_op("multu_small", 6'b011001, 32'd12345, 32'd678, 5'd0, 32'd8369910, 1'b0, 32);
      run_op("mfhi_small", 6'b010000, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1);

      // OR under backpressure while a competing request is offered
      send(6'b100101, 32'h0000_00F0, 32'h0000_0F0F, 5'd0);
      wait_rsp(lat);
      held = rsp_result;
      check_eq("or_result", held, 32'h0000_0FFF);
      req_funct = 6'b100000;
      req_a     = 32'd1;
      req_b     = 32'd1;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_eq("bp_valid", {31'b0, rsp_valid}, 32'd1);
         check_eq("bp_result", rsp_result, 32'h0000_0FFF);
         check_eq("bp_err", {31'b0, rsp_err}, 32'd0);
         check_eq("bp_req_ready", {31'b0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      take_rsp("or");
      run_op("mflo_after_bp", 6'b010010, 32'd0, 32'd0, 5'd0, 32'd8369910, 1'b0, 1);

      // Illegal function code
      send(6'b111111, 32'd9, 32'd9, 5'd0);
      check_eq("ill_alu_signal", {26'b0, alu_signal}, 32'd0);
      check_eq("ill_shf_signal", {26'b0, shf_signal}, 32'd0);
      wait_rsp(lat);
      check_eq("ill_result", rsp_result, 32'd0);
      check_eq("ill_err", {31'b0, rsp_err}, 32'd1);
      take_rsp("ill");

      // Reset while the MUL counter holds 10
      send(6'b011001, 32'hFFFFFFFF, 32'd3, 5'd0);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      check_eq("mid_busy_before", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_eq("mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check_eq("mid_req_ready", {31'b0, req_ready}, 32'd1);
      check_eq("mid_busy", {31'b0, busy}, 32'd0);
      check_eq("mid_rsp_result", rsp_result, 32'd0);
      run_op("mid_mfhi", 6'b010000, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1);
      run_op("mid_mflo", 6'b010010, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
